// File: rtl/fetch_controller_if.sv
// Fetch-controller bus bundle.
// Groups the loader handshake, the instruction-store write port, the
// fetch-stage PC/decode signals and the hazard/flush/control lines.
//   master : the fetch controller (drives load_ready, imem_*, PC, if_valid, done)
//   slave  : the surrounding loader / fetch stage / hazard unit
interface fetch_controller_if #(parameter int ADDR_W = 8) ();
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [7:0]        imem_wdata;
  logic [ADDR_W-1:0] instruction_address;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] jump_address;
  logic              stall;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_target;
  logic              if_valid;
  logic              done;
  logic              restart;

  modport master (
    input  load_valid, load_data, load_last, opcode, jump_address,
           stall, flush_req, flush_target, restart,
    output load_ready, imem_we, imem_waddr, imem_wdata,
           instruction_address, if_valid, done
  );

  modport slave (
    output load_valid, load_data, load_last, opcode, jump_address,
           stall, flush_req, flush_target, restart,
    input  load_ready, imem_we, imem_waddr, imem_wdata,
           instruction_address, if_valid, done
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer.
// Loads the instruction store through a valid/ready loader port, then runs
// the program counter with flush > stall > jump > increment priority, and
// parks in DONE once the PC walks past the loaded program.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-low
//   bus   : fetch_controller_if.master (loader, imem write, PC, hazards, status)
module fetch_controller #(
  parameter int PROG_DEPTH = 8,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  bus
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One extra bit so a full store (PROG_DEPTH == 2**ADDR_W) is countable.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PROG_DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_wcnt;
  logic [ADDR_W:0]   r_prog_len;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_we;
  logic              r_load_ready;
  logic              r_done;

  logic              w_accept;
  logic              w_load_exit;
  logic [ADDR_W:0]   w_wcnt_nxt;
  logic              w_end;
  logic              w_jump;

  assign w_accept    = (r_state == S_LOAD) & r_load_ready & bus.load_valid;
  assign w_wcnt_nxt  = r_wcnt + (ADDR_W+1)'(1);
  assign w_load_exit = w_accept & (bus.load_last | (w_wcnt_nxt == DEPTH));
  assign w_end       = ({1'b0, r_pc} >= r_prog_len);
  assign w_jump      = (bus.opcode == 2'b11);

  // Jump slots are consumed here and never forwarded to IF/ID.
  assign bus.if_valid = (r_state == S_RUN) & ~bus.flush_req & ~bus.stall &
                        ~w_jump & ~w_end;

  assign bus.load_ready          = r_load_ready;
  assign bus.imem_we             = r_we;
  assign bus.imem_waddr          = r_waddr;
  assign bus.imem_wdata          = r_wdata;
  assign bus.instruction_address = r_pc;
  assign bus.done                = r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_wcnt       <= '0;
      r_prog_len   <= '0;
      r_pc         <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_load_ready <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Store write lags acceptance by one cycle.
      r_we <= w_accept;
      if (w_accept) begin
        r_waddr <= r_wcnt[ADDR_W-1:0];
        r_wdata <= bus.load_data;
      end

      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_wcnt <= w_wcnt_nxt;
            if (w_load_exit) begin
              r_prog_len   <= w_wcnt_nxt;
              r_pc         <= '0;
              r_load_ready <= 1'b0;
              r_state      <= S_RUN;
            end else begin
              r_load_ready <= 1'b1;
            end
          end else begin
            r_load_ready <= (r_wcnt < DEPTH);
          end
        end
        S_RUN: begin
          // End-of-program beats stall/jump; only a flush can pull us back.
          if (bus.flush_req) begin
            r_pc <= bus.flush_target;
          end else if (w_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (bus.stall) begin
            r_pc <= r_pc;
          end else if (w_jump) begin
            r_pc <= bus.jump_address;
          end else begin
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        S_DONE: begin
          if (bus.restart) begin
            r_state      <= S_LOAD;
            r_wcnt       <= '0;
            r_prog_len   <= '0;
            r_pc         <= '0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_controller_if #(.ADDR_W(8)) bus ();

  fetch_controller #(.PROG_DEPTH(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One RUN slot: drive decode inputs, check PC and if_valid, advance.
  task automatic slot(input string tag, input logic [1:0] op, input logic [7:0] ja,
                      input logic [7:0] exp_pc, input logic exp_v);
    bus.opcode       = op;
    bus.jump_address = ja;
    #1;
    chk({tag, "_pc"}, bus.instruction_address, exp_pc);
    chk({tag, "_ifv"}, bus.if_valid, exp_v);
    tick();
  endtask

  // One accepted loader beat; the write shows up after the edge.
  task automatic load_word(input string tag, input logic [7:0] idx,
                           input logic [7:0] data, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    tick();
    chk({tag, "_we"}, bus.imem_we, 1'b1);
    chk({tag, "_waddr"}, bus.imem_waddr, idx);
    chk({tag, "_wdata"}, bus.imem_wdata, data);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  logic [7:0] prog6 [6];

  initial begin
    prog6[0] = 8'h08; prog6[1] = 8'h4B; prog6[2] = 8'h42;
    prog6[3] = 8'hC5; prog6[4] = 8'h00; prog6[5] = 8'h45;

    reset            = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.load_last    = 1'b0;
    bus.opcode       = '0;
    bus.jump_address = '0;
    bus.stall        = 1'b0;
    bus.flush_req    = 1'b0;
    bus.flush_target = '0;
    bus.restart      = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_load_ready", bus.load_ready, 1'b0);
    chk("rst_we", bus.imem_we, 1'b0);
    chk("rst_waddr", bus.imem_waddr, 8'h00);
    chk("rst_wdata", bus.imem_wdata, 8'h00);
    chk("rst_pc", bus.instruction_address, 8'h00);
    chk("rst_ifv", bus.if_valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    reset = 1'b1;
    tick();
    chk("rel_load_ready", bus.load_ready, 1'b1);

    // Load 6 words, last on the 6th
    for (int i = 0; i < 6; i++)
      load_word("ld6", 8'(i), prog6[i], i == 5);
    chk("ld6_exit_ready", bus.load_ready, 1'b0);
    chk("ld6_exit_pc", bus.instruction_address, 8'h00);

    // Run: 0,1,2 valid; 3 jumps to 5; 5 valid; 6 is past end
    slot("r6_0", 2'b00, 8'h00, 8'h00, 1'b1);
    chk("r6_we_idle", bus.imem_we, 1'b0);
    slot("r6_1", 2'b01, 8'h00, 8'h01, 1'b1);
    slot("r6_2", 2'b01, 8'h00, 8'h02, 1'b1);
    slot("r6_3", 2'b11, 8'h05, 8'h03, 1'b0);
    slot("r6_5", 2'b01, 8'h00, 8'h05, 1'b1);
    chk("r6_done_early", bus.done, 1'b0);
    slot("r6_6", 2'b00, 8'h00, 8'h06, 1'b0);
    chk("r6_done", bus.done, 1'b1);
    chk("r6_done_pc", bus.instruction_address, 8'h06);
    slot("r6_hold", 2'b00, 8'h00, 8'h06, 1'b0);

    // Restart from DONE
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("rs_done", bus.done, 1'b0);
    chk("rs_load_ready", bus.load_ready, 1'b1);
    chk("rs_pc", bus.instruction_address, 8'h00);

    // Load 8 words with no load_last: auto exit
    for (int i = 0; i < 8; i++)
      load_word("ld8", 8'(i), 8'(8'h10 + i), 1'b0);
    chk("ld8_exit_ready", bus.load_ready, 1'b0);

    // 9th beat ignored; restart outside DONE ignored
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    bus.restart    = 1'b1;
    slot("r8_0", 2'b00, 8'h00, 8'h00, 1'b1);
    chk("ld9_no_we", bus.imem_we, 1'b0);
    chk("ld9_ready", bus.load_ready, 1'b0);
    bus.load_valid = 1'b0;
    bus.restart    = 1'b0;
    slot("r8_1", 2'b00, 8'h00, 8'h01, 1'b1);
    slot("r8_2", 2'b00, 8'h00, 8'h02, 1'b1);

    // Stall on a jump slot for 3 cycles, then jump to 7
    bus.stall = 1'b1;
    slot("stj_a", 2'b11, 8'h07, 8'h03, 1'b0);
    slot("stj_b", 2'b11, 8'h07, 8'h03, 1'b0);
    slot("stj_c", 2'b11, 8'h07, 8'h03, 1'b0);
    bus.stall = 1'b0;
    slot("stj_go", 2'b11, 8'h07, 8'h03, 1'b0);
    slot("r8_7", 2'b00, 8'h00, 8'h07, 1'b1);

    // At end of program, flush + stall redirect to 1 and keep RUN
    bus.flush_req    = 1'b1;
    bus.flush_target = 8'h01;
    bus.stall        = 1'b1;
    slot("fl_end", 2'b00, 8'h00, 8'h08, 1'b0);
    chk("fl_no_done", bus.done, 1'b0);
    bus.flush_req = 1'b0;
    bus.stall     = 1'b0;
    slot("fl_tgt", 2'b00, 8'h00, 8'h01, 1'b1);
    chk("fl_next_pc", bus.instruction_address, 8'h02);

    // Reset mid-run
    reset = 1'b0;
    tick();
    chk("rr_pc", bus.instruction_address, 8'h00);
    chk("rr_done", bus.done, 1'b0);
    chk("rr_ready", bus.load_ready, 1'b0);
    chk("rr_ifv", bus.if_valid, 1'b0);
    chk("rr_we", bus.imem_we, 1'b0);
    reset = 1'b1;
    tick();
    chk("rr_rel_ready", bus.load_ready, 1'b1);

    // Reset mid-load after 3 words; beat in the reset cycle is dropped
    for (int i = 0; i < 3; i++)
      load_word("ldr", 8'(i), 8'(8'hA0 + i), 1'b0);
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    tick();
    chk("rl_we", bus.imem_we, 1'b0);
    chk("rl_ready", bus.load_ready, 1'b0);
    chk("rl_waddr", bus.imem_waddr, 8'h00);
    chk("rl_wdata", bus.imem_wdata, 8'h00);
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    tick();
    chk("rl_rel_ready", bus.load_ready, 1'b1);

    // Reload 2 words; jump past end reaches DONE one cycle after the jump
    load_word("ld2_0", 8'h00, 8'hC5, 1'b0);
    load_word("ld2_1", 8'h01, 8'h00, 1'b1);
    chk("ld2_exit_ready", bus.load_ready, 1'b0);
    slot("jp_0", 2'b11, 8'h05, 8'h00, 1'b0);
    chk("jp_not_done", bus.done, 1'b0);
    slot("jp_5", 2'b00, 8'h00, 8'h05, 1'b0);
    chk("jp_done", bus.done, 1'b1);
    chk("jp_done_pc", bus.instruction_address, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the 8-bit instruction-fetch stage. It owns the program counter that drives `instruction_address`, and it loads the instruction store through a valid/ready loader port. It redirects the PC on jumps (opcode `2'b11`), on stalls and on flush requests from later stages, and it stops cleanly at the end of the loaded program. It sits between the program loader / hazard unit and the fetch stage, and feeds the IF/ID register's valid bit.

## Interface
- `PROG_DEPTH`, 8: instruction-store entries; maximum program length (≤ 256).
- `ADDR_W`, 8: PC / address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  loader presents `load_data`.
- `load_data`  in  8  instruction word.
- `load_last`  in  1  qualifies the final word of the program (meaningful only with `load_valid`).
- `load_ready`  out  1  controller accepts a loader word this cycle.
- `imem_we`  out  1  instruction-store write strobe.
- `imem_waddr`  out  8  write address.
- `imem_wdata`  out  8  write data.
- `instruction_address`  out  8  PC to the fetch stage.
- `opcode`  in  2  decoded opcode of the currently fetched word.
- `jump_address`  in  8  jump target from the fetch stage.
- `stall`  in  1  hazard unit holds the PC.
- `flush_req`  in  1  later stage redirects fetch.
- `flush_target`  in  8  redirect address.
- `if_valid`  out  1  the current fetch slot is a real instruction for IF/ID.
- `done`  out  1  program finished.
- `restart`  in  1  in DONE, return to LOAD.

## Operation
- **States:** LOAD, RUN, DONE. Reset enters LOAD.
- **Reset values:**
  - Internal: `wcnt` = 0, `prog_len` = 0.
  - Outputs: `instruction_address` = 0, `load_ready` = 0, `imem_we` = 0, `imem_waddr` = 0, `imem_wdata` = 0, `if_valid` = 0, `done` = 0.
  - `load_ready` rises the first cycle after `reset` goes high.
- **LOAD:**
  - `load_ready` = 1 while `wcnt < PROG_DEPTH`.
  - On `load_valid & load_ready`:
    - write `load_data` to `wcnt` (`imem_we` = 1, `imem_waddr` = `wcnt`, `imem_wdata` = `load_data`, registered, visible next cycle);
    - `wcnt` += 1.
  - Exit to RUN when an accepted word has `load_last` = 1, or when the accepted word makes `wcnt` == `PROG_DEPTH`.
  - On exit:
    - `prog_len` = number of words written;
    - `instruction_address` = 0;
    - `load_ready` drops the same edge.
  - `load_valid` while `load_ready` = 0 is ignored (no write, no count).
- **RUN:** next-PC priority, highest first:
  1. `flush_req`: PC ← `flush_target`; `if_valid` = 0 this cycle.
  2. `stall`: PC holds; `if_valid` = 0.
  3. `opcode` == `2'b11`: PC ← `jump_address`; `if_valid` = 0. The jump is consumed in fetch and not forwarded.
  4. Otherwise: PC ← PC + 1, modulo 256; `if_valid` = 1.
  - `if_valid` is combinational from state, PC and the inputs above.
  - `if_valid` is additionally forced to 0 when PC ≥ `prog_len`.
- **End of program:** in RUN with PC ≥ `prog_len` and no `flush_req`:
  - next state DONE; PC holds.
  - `flush_req` in that same cycle takes priority and the controller stays in RUN at `flush_target`.
  - A jump or flush to an address ≥ `prog_len` reaches DONE one cycle later.
- **DONE:**
  - `done` = 1 (registered), `if_valid` = 0, PC holds.
  - `restart` → LOAD: clear `wcnt`, `prog_len`, PC and `done`; `load_ready` = 1 next cycle.
  - `restart` outside DONE is ignored.
- **Reset mid-operation:** returns to LOAD with all reset values, regardless of state or handshake in progress. A loader beat in the reset cycle is discarded.
- **Simultaneous events:**
  - `stall` + jump: stall wins; the jump is re-evaluated when the stall releases.
  - `flush_req` + `stall`: flush wins.

## Timing
- Loader: one word per cycle at full throughput; the store write is one cycle after acceptance.
- LOAD→RUN: first fetch of address 0 is valid in the cycle after the last accepted word.
- PC updates on the edge after the decision. Jump penalty is exactly one invalid slot (the jump slot itself).
- Flush: redirected fetch appears in the next cycle.
- RUN→DONE: `done` asserts one cycle after PC reaches `prog_len`.

## Test plan
- **Load 6 words, last on word 6:**
  - Words: `8'h08`, `8'h4B`, `8'h42`, `8'hC5`, `8'h00`, `8'h45`; `load_last` on the 6th.
  - Required: writes to 0..5, then `prog_len` = 6 and RUN at PC 0.
  - With `opcode` driven from memory: `if_valid` for PCs 0,1,2; PC 3 is a jump (`if_valid` 0) to `jump_address`; execution continues from the target; `done` after PC 6.
- **Load 8 words, no `load_last`:**
  - Auto-exit to RUN after the 8th accept.
  - A 9th `load_valid` sees `load_ready` = 0 and causes no write.
- **Stall during jump cycle:**
  - Hold `stall` 3 cycles while `opcode` = 11 at PC 3.
  - PC stays 3 and `if_valid` stays 0; the jump is taken on the first unstalled cycle.
- **`flush_req` with `stall` and at end of program:**
  - `flush_target` = 1 → PC = 1 next cycle, no DONE transition.
- **Reset low mid-load (after 3 words) and mid-run:**
  - All outputs return to reset values; `wcnt` restarts at 0 and the first write after reset goes to address 0.
- **Restart and jump past end:**
  - In DONE, pulse `restart` → LOAD with `load_ready` = 1.
  - Reload 2 words with a jump to 5 → DONE one cycle after the jump.
